// File: rtl/accel_axi_pkg.sv
// Shared constants and address-map decode for the accelerator AXI4-Lite register file.
package accel_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STATUS_NEW_BIT = 0;
    localparam int STATUS_OVR_BIT = 1;
    localparam int IE_BIT         = 0;

    typedef enum logic [1:0] {
        REGION_RW,
        REGION_CH,
        REGION_STATUS,
        REGION_UNMAPPED
    } region_e;

    // Word map: RW registers, then one word per channel, then STATUS, then a hole.
    function automatic region_e decode_region(input int idx, input int num_rw, input int num_ch);
        if (idx < num_rw)          return REGION_RW;
        if (idx < num_rw + num_ch) return REGION_CH;
        if (idx == num_rw + num_ch) return REGION_STATUS;
        return REGION_UNMAPPED;
    endfunction

endpackage

// File: rtl/accel_sample_capture.sv
// Sample capture: live registers, coherent hold registers for CH1..n-1,
// NEW/OVR status flags and the registered interrupt.
module accel_sample_capture
    import accel_axi_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_valid,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] sample_data,
    input  logic                           ch0_read,
    input  logic                           clr_new,
    input  logic                           clr_ovr,
    input  logic                           ie,
    output logic [NUM_CH*SAMPLE_WIDTH-1:0] ch_data,
    output logic                           new_flag,
    output logic                           ovr_flag,
    output logic                           irq
);

    logic [NUM_CH*SAMPLE_WIDTH-1:0] live_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= '0;
        end else if (sample_valid) begin
            live_q <= sample_data;
        end
    end

    // CH0 is read straight from the live register; the others from their snapshot.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        if (k == 0) begin : g_live
            assign ch_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = live_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end else begin : g_hold
            logic [SAMPLE_WIDTH-1:0] hold_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= '0;
                end else if (ch0_read) begin
                    hold_q <= live_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                end
            end

            assign ch_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = hold_q;
        end
    end

    // A fresh sample always wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_flag <= 1'b0;
            ovr_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (sample_valid) begin
                new_flag <= 1'b1;
            end else if (ch0_read || clr_new) begin
                new_flag <= 1'b0;
            end

            if (sample_valid && new_flag) begin
                ovr_flag <= 1'b1;
            end else if (clr_ovr) begin
                ovr_flag <= 1'b0;
            end

            irq <= new_flag & ie;
        end
    end

endmodule

// File: rtl/accel_axi_regfile.sv
// AXI4-Lite slave exposing RW control registers, sign-extended sample channels
// and a NEW/OVR status word; handshake and address decode live here.
module accel_axi_regfile
    import accel_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_RW_REGS      = 4,
    parameter int C_NUM_CH           = 3,
    parameter int C_SAMPLE_WIDTH     = 16
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,

    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,

    input  logic                                sample_valid,
    input  logic [C_NUM_CH*C_SAMPLE_WIDTH-1:0]  sample_data,

    output logic                                irq
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] rw_regs [C_NUM_RW_REGS];

    logic                          bvalid_q;
    logic [1:0]                    bresp_q;
    logic                          rvalid_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

    int      aw_idx;
    int      ar_idx;
    region_e aw_region;
    region_e ar_region;

    logic wr_accept;
    logic rd_accept;
    logic wr_mapped;
    logic status_wr;
    logic clr_new;
    logic clr_ovr;
    logic ch0_read;

    logic [C_NUM_CH*C_SAMPLE_WIDTH-1:0] ch_data;
    logic                               new_flag;
    logic                               ovr_flag;

    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
    logic [1:0]                    rd_resp;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_idx    = int'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign ar_idx    = int'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign aw_region = decode_region(aw_idx, C_NUM_RW_REGS, C_NUM_CH);
    assign ar_region = decode_region(ar_idx, C_NUM_RW_REGS, C_NUM_CH);

    // Ready is offered only in the accepting cycle, and never while in reset.
    assign wr_accept = S_AXI_ARESETN & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign rd_accept = S_AXI_ARESETN & S_AXI_ARVALID & ~rvalid_q;

    assign S_AXI_AWREADY = wr_accept;
    assign S_AXI_WREADY  = wr_accept;
    assign S_AXI_ARREADY = rd_accept;

    assign wr_mapped = (aw_region == REGION_RW) || (aw_region == REGION_STATUS);
    assign status_wr = wr_accept && (aw_region == REGION_STATUS) && S_AXI_WSTRB[0];
    assign clr_new   = status_wr && S_AXI_WDATA[STATUS_NEW_BIT];
    assign clr_ovr   = status_wr && S_AXI_WDATA[STATUS_OVR_BIT];
    assign ch0_read  = rd_accept && (ar_region == REGION_CH) && (ar_idx == C_NUM_RW_REGS);

    // NOTE: the RW file is only a handful of flops, so it is cleared by reset
    // along with everything else; a true RAM would be left unreset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < C_NUM_RW_REGS; i++) begin
                rw_regs[i] <= '0;
            end
        end else if (wr_accept && (aw_region == REGION_RW)) begin
            for (int i = 0; i < C_NUM_RW_REGS; i++) begin
                if (aw_idx == i) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (S_AXI_WSTRB[b]) begin
                            rw_regs[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (wr_accept) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        unique case (ar_region)
            REGION_RW: begin
                for (int i = 0; i < C_NUM_RW_REGS; i++) begin
                    if (ar_idx == i) rd_data = rw_regs[i];
                end
            end
            REGION_CH: begin
                for (int k = 0; k < C_NUM_CH; k++) begin
                    if (ar_idx == C_NUM_RW_REGS + k) begin
                        rd_data = C_S_AXI_DATA_WIDTH'(signed'(ch_data[k*C_SAMPLE_WIDTH +: C_SAMPLE_WIDTH]));
                    end
                end
            end
            REGION_STATUS: begin
                rd_data[STATUS_NEW_BIT] = new_flag;
                rd_data[STATUS_OVR_BIT] = ovr_flag;
            end
            default: begin
                rd_resp = RESP_SLVERR;
            end
        endcase
    end

    // Read data is captured at acceptance, so a same-cycle write is not visible.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (rd_accept) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp;
            rdata_q  <= rd_data;
        end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;

    accel_sample_capture #(
        .NUM_CH       (C_NUM_CH),
        .SAMPLE_WIDTH (C_SAMPLE_WIDTH)
    ) u_capture (
        .clk          (S_AXI_ACLK),
        .rst_n        (S_AXI_ARESETN),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ch0_read     (ch0_read),
        .clr_new      (clr_new),
        .clr_ovr      (clr_ovr),
        .ie           (rw_regs[0][IE_BIT]),
        .ch_data      (ch_data),
        .new_flag     (new_flag),
        .ovr_flag     (ovr_flag),
        .irq          (irq)
    );

endmodule

// File: tb/tb_accel_axi_regfile.sv
// Self-checking bench for accel_axi_regfile: directed scenarios plus a random
// mix of AXI reads, writes and sample strobes against a register-map model.
module tb_accel_axi_regfile;

    localparam int AW         = 6;
    localparam int NUM_RW     = 4;
    localparam int NUM_CH     = 3;
    localparam int SW         = 16;
    localparam int CH_BASE    = NUM_RW;
    localparam int STATUS_IDX = NUM_RW + NUM_CH;
    localparam int TMO        = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [AW-1:0]        awaddr, araddr;
    logic [2:0]           awprot, arprot;
    logic                 awvalid, awready, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rvalid, rready;
    logic [31:0]          wdata, rdata;
    logic [3:0]           wstrb;
    logic [1:0]           bresp, rresp;
    logic                 sample_valid;
    logic [NUM_CH*SW-1:0] sample_data;
    logic                 irq;

    int tests_run    = 0;
    int tests_failed = 0;

    accel_axi_regfile #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_NUM_RW_REGS      (NUM_RW),
        .C_NUM_CH           (NUM_CH),
        .C_SAMPLE_WIDTH     (SW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .irq           (irq)
    );

    // Reference model of the register map
    logic [31:0]   m_rw   [NUM_RW];
    logic [SW-1:0] m_live [NUM_CH];
    logic [SW-1:0] m_hold [NUM_CH];
    logic          m_new, m_ovr;

    function automatic void model_reset();
        for (int i = 0; i < NUM_RW; i++) m_rw[i] = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_live[k] = '0;
            m_hold[k] = '0;
        end
        m_new = 1'b0;
        m_ovr = 1'b0;
    endfunction

    function automatic logic [31:0] sext(input logic [SW-1:0] v);
        return {{(32-SW){v[SW-1]}}, v};
    endfunction

    function automatic void model_sample(input logic [NUM_CH*SW-1:0] smp, input logic was_new);
        for (int k = 0; k < NUM_CH; k++) m_live[k] = smp[k*SW +: SW];
        if (was_new) m_ovr = 1'b1;
        m_new = 1'b1;
    endfunction

    function automatic void model_read(input int idx, output logic [31:0] d, output logic [1:0] r);
        d = '0;
        r = 2'b00;
        if (idx < NUM_RW) begin
            d = m_rw[idx];
        end else if (idx == CH_BASE) begin
            d = sext(m_live[0]);
            for (int k = 0; k < NUM_CH; k++) m_hold[k] = m_live[k];
            m_new = 1'b0;
        end else if (idx < CH_BASE + NUM_CH) begin
            d = sext(m_hold[idx - CH_BASE]);
        end else if (idx == STATUS_IDX) begin
            d = {30'b0, m_ovr, m_new};
        end else begin
            r = 2'b10;
        end
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                                        input bit with_sample, input logic [NUM_CH*SW-1:0] smp,
                                        output logic [1:0] r);
        logic was_new;
        was_new = m_new;
        r = 2'b10;
        if (idx < NUM_RW) begin
            r = 2'b00;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) m_rw[idx][8*b +: 8] = data[8*b +: 8];
            end
        end else if (idx == STATUS_IDX) begin
            r = 2'b00;
            if (strb[0] && data[0]) m_new = 1'b0;
            if (strb[0] && data[1]) m_ovr = 1'b0;
        end
        if (with_sample) model_sample(smp, was_new);
    endfunction

    // Bus drivers
    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             input bit with_sample, input logic [NUM_CH*SW-1:0] smp,
                             output logic [1:0] r);
        int n;
        @(negedge clk);
        awaddr  = AW'(idx*4 + int'($urandom_range(0, 3)));
        awprot  = 3'($urandom_range(0, 7));
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            tests_run++;
            tests_failed++;
            $display("FAIL write_handshake idx=%0d: got no AWREADY/WREADY, required within %0d cycles", idx, TMO);
        end
        if (with_sample) begin
            sample_valid = 1'b1;
            sample_data  = smp;
        end
        @(negedge clk);
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        sample_valid = 1'b0;
        n = 0;
        while (!bvalid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            tests_run++;
            tests_failed++;
            $display("FAIL write_response idx=%0d: got no BVALID, required within %0d cycles", idx, TMO);
        end
        r      = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input int idx, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        araddr  = AW'(idx*4 + int'($urandom_range(0, 3)));
        arprot  = 3'($urandom_range(0, 7));
        arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            tests_run++;
            tests_failed++;
            $display("FAIL read_handshake idx=%0d: got no ARREADY, required within %0d cycles", idx, TMO);
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            tests_run++;
            tests_failed++;
            $display("FAIL read_response idx=%0d: got no RVALID, required within %0d cycles", idx, TMO);
        end
        d      = rdata;
        r      = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic do_read(input int idx, output logic [31:0] d, output logic [1:0] r,
                           output logic [31:0] ed, output logic [1:0] er);
        model_read(idx, ed, er);
        axi_read(idx, d, r);
    endtask

    task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                            input bit with_sample, input logic [NUM_CH*SW-1:0] smp,
                            output logic [1:0] r, output logic [1:0] er);
        axi_write(idx, data, strb, with_sample, smp, r);
        model_write(idx, data, strb, with_sample, smp, er);
    endtask

    task automatic do_sample(input logic [NUM_CH*SW-1:0] smp);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = smp;
        @(negedge clk);
        sample_valid = 1'b0;
        model_sample(smp, m_new);
    endtask

    // Scenarios
    task automatic test_reset();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int idx_list[4] = '{0, 3, CH_BASE + 1, STATUS_IDX};
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0;
        sample_valid = 1'b0; sample_data = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, irq} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, required all zero",
                     {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, irq});
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        foreach (idx_list[i]) begin
            do_read(idx_list[i], d, r, ed, er);
            tests_run++;
            if ({r, d} !== {2'b00, 32'h0}) begin
                tests_failed++;
                $display("FAIL reset_read idx=%0d: got resp=%b data=%h, required resp=00 data=00000000",
                         idx_list[i], r, d);
            end
        end
    endtask

    task automatic test_rw_strobe();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        do_write(1, 32'hABCD_0001, 4'b1111, 1'b0, '0, r, er);
        tests_run++;
        if (r !== 2'b00) begin
            tests_failed++;
            $display("FAIL rw_write_bresp: got %b, required 00", r);
        end
        do_read(1, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b00, 32'hABCD_0001}) begin
            tests_failed++;
            $display("FAIL rw_readback: got resp=%b data=%h, required resp=00 data=abcd0001", r, d);
        end
        do_write(0, 32'hFFFF_FFFF, 4'b0101, 1'b0, '0, r, er);
        do_read(0, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b00, 32'h00FF_00FF}) begin
            tests_failed++;
            $display("FAIL rw_strobe: got resp=%b data=%h, required resp=00 data=00ff00ff", r, d);
        end
    endtask

    task automatic test_coherent_sample();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        do_write(STATUS_IDX, 32'h3, 4'h1, 1'b0, '0, r, er);
        do_write(0, 32'h1, 4'h1, 1'b0, '0, r, er);
        do_sample({16'h1234, 16'h0005, 16'h8000});
        #1;
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_latency_early: got %b, required 0 in the cycle NEW sets", irq);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_assert: got %b, required 1 one cycle after NEW", irq);
        end
        do_read(CH_BASE, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b00, 32'hFFFF_8000}) begin
            tests_failed++;
            $display("FAIL ch0_sign_extend: got resp=%b data=%h, required resp=00 data=ffff8000", r, d);
        end
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_clear_on_ch0: got %b, required 0", irq);
        end
        do_read(STATUS_IDX, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL status_after_ch0: got %h, required 00000000", d);
        end
        do_sample({16'hAAAA, 16'h7777, 16'h0001});
        do_read(CH_BASE + 1, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b00, 32'h0000_0005}) begin
            tests_failed++;
            $display("FAIL ch1_hold: got resp=%b data=%h, required resp=00 data=00000005", r, d);
        end
        do_read(CH_BASE + 2, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b00, 32'h0000_1234}) begin
            tests_failed++;
            $display("FAIL ch2_hold: got resp=%b data=%h, required resp=00 data=00001234", r, d);
        end
        do_read(CH_BASE, d, r, ed, er);
        do_read(CH_BASE + 1, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b00, 32'h0000_7777}) begin
            tests_failed++;
            $display("FAIL ch1_refresh: got resp=%b data=%h, required resp=00 data=00007777", r, d);
        end
    endtask

    task automatic test_status_flags();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        do_write(STATUS_IDX, 32'h3, 4'h1, 1'b0, '0, r, er);
        do_sample(48'h0001_0002_0003);
        do_sample(48'h0004_0005_0006);
        do_read(STATUS_IDX, d, r, ed, er);
        tests_run++;
        if (d !== 32'h3) begin
            tests_failed++;
            $display("FAIL status_overrun: got %h, required 00000003", d);
        end
        do_write(STATUS_IDX, 32'h2, 4'h1, 1'b0, '0, r, er);
        do_read(STATUS_IDX, d, r, ed, er);
        tests_run++;
        if (d !== 32'h1) begin
            tests_failed++;
            $display("FAIL status_w1c_ovr: got %h, required 00000001", d);
        end
        do_write(STATUS_IDX, 32'h1, 4'h1, 1'b1, 48'h0007_0008_0009, r, er);
        do_read(STATUS_IDX, d, r, ed, er);
        tests_run++;
        if (d[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL status_set_wins: got NEW=%b, required 1", d[0]);
        end
        tests_run++;
        if ({r, d} !== {er, ed}) begin
            tests_failed++;
            $display("FAIL status_set_wins_word: got %h, required %h", d, ed);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        do_write(CH_BASE + 1, $urandom, 4'hF, 1'b0, '0, r, er);
        tests_run++;
        if (r !== 2'b10) begin
            tests_failed++;
            $display("FAIL ch_write_bresp: got %b, required 10", r);
        end
        do_write(9, $urandom, 4'hF, 1'b0, '0, r, er);
        tests_run++;
        if (r !== 2'b10) begin
            tests_failed++;
            $display("FAIL unmapped_write_bresp: got %b, required 10", r);
        end
        do_read(15, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b10, 32'h0}) begin
            tests_failed++;
            $display("FAIL unmapped_read: got resp=%b data=%h, required resp=10 data=00000000", r, d);
        end
        for (int idx = 0; idx <= STATUS_IDX; idx++) begin
            if (idx == CH_BASE) continue;
            do_read(idx, d, r, ed, er);
            tests_run++;
            if ({r, d} !== {er, ed}) begin
                tests_failed++;
                $display("FAIL no_side_effect idx=%0d: got resp=%b data=%h, required resp=%b data=%h",
                         idx, r, d, er, ed);
            end
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] d, old_val, nv;
        logic [1:0]  r, rr, er;
        old_val = m_rw[2];
        nv      = $urandom;
        fork
            axi_write(2, nv, 4'hF, 1'b0, '0, r);
            axi_read(2, d, rr);
        join
        model_write(2, nv, 4'hF, 1'b0, '0, er);
        tests_run++;
        if ({rr, d} !== {2'b00, old_val}) begin
            tests_failed++;
            $display("FAIL same_cycle_rw: got resp=%b data=%h, required resp=00 data=%h", rr, d, old_val);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        logic [63:0] r64;
        int          idx;
        for (int i = 0; i < 80; i++) begin
            idx = $urandom_range(0, 15);
            case ($urandom_range(0, 2))
                0: begin
                    do_write(idx, $urandom, 4'($urandom_range(0, 15)), 1'b0, '0, r, er);
                    tests_run++;
                    if (r !== er) begin
                        tests_failed++;
                        $display("FAIL rand_bresp idx=%0d: got %b, required %b", idx, r, er);
                    end
                end
                1: begin
                    do_read(idx, d, r, ed, er);
                    tests_run++;
                    if ({r, d} !== {er, ed}) begin
                        tests_failed++;
                        $display("FAIL rand_read idx=%0d: got resp=%b data=%h, required resp=%b data=%h",
                                 idx, r, d, er, ed);
                    end
                end
                default: begin
                    r64 = {$urandom, $urandom};
                    do_sample(r64[NUM_CH*SW-1:0]);
                end
            endcase
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (irq !== (m_new & m_rw[0][0])) begin
            tests_failed++;
            $display("FAIL rand_irq: got %b, required %b", irq, m_new & m_rw[0][0]);
        end
    endtask

    task automatic test_bresp_stall_reset();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int          n;
        @(negedge clk);
        awaddr = AW'(2*4); wdata = 32'h5A5A_A5A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        n = 0;
        while (!awready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= TMO) begin
            tests_failed++;
            $display("FAIL stall_first_accept: got no AWREADY, required within %0d cycles", TMO);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if ({bvalid, awready, wready} !== 3'b100) begin
                tests_failed++;
                $display("FAIL stall_hold cycle=%0d: got bvalid/awready/wready=%b, required 100",
                         c, {bvalid, awready, wready});
            end
        end
        bready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bvalid, awready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL stall_release: got bvalid/awready=%b, required 01", {bvalid, awready});
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, irq} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %h, required all zero",
                     {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, irq});
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bvalid, rvalid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL post_reset_response: got bvalid/rvalid=%b, required 00", {bvalid, rvalid});
        end
        do_read(2, d, r, ed, er);
        tests_run++;
        if ({r, d} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL post_reset_reg: got resp=%b data=%h, required resp=00 data=00000000", r, d);
        end
    endtask

    initial begin
        test_reset();
        test_rw_strobe();
        test_coherent_sample();
        test_status_flags();
        test_slverr();
        test_concurrent();
        test_random();
        test_bresp_stall_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required finish within 300000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/accel_axi_regfile.md
ACCEL_AXI_REGFILE -- requirements
Module: accel_axi_regfile

Interface
REQ-001 Parameters SHALL be: C_S_AXI_DATA_WIDTH, default 32, AXI data width (32 only); C_S_AXI_ADDR_WIDTH, default 6, byte-address width; C_NUM_RW_REGS, default 4, count of read/write registers (1..8); C_NUM_CH, default 3, number of sample channels/axes (1..4); C_SAMPLE_WIDTH, default 16, signed sample width (8..32).
REQ-002 Clock and reset: S_AXI_ACLK, in, 1, the single clock. S_AXI_ARESETN, in, 1, asynchronous active-low reset.
REQ-003 Write address channel: S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH; S_AXI_AWPROT in 3, ignored; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-004 Write data channel: S_AXI_WDATA in 32; S_AXI_WSTRB in 4, byte enables; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-005 Write response channel: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-006 Read channels: S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3, ignored; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1; S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-007 Sample port: sample_valid in 1, one-cycle strobe; sample_data in C_NUM_CH*C_SAMPLE_WIDTH, channel k at bits [k*W +: W].
REQ-008 irq out 1, level interrupt.

Function
REQ-009 Word map (byte address = 4*index): index 0..C_NUM_RW_REGS-1 RW; next C_NUM_CH indices CH0..CHn-1 (RO); next index STATUS; anything above is unmapped; address bits [1:0] are ignored.
REQ-010 RW register 0 bit 0 SHALL be IE; all RW bits are plain storage.
REQ-011 A write SHALL be accepted in the cycle both AWVALID and WVALID are high and BVALID is low; AWREADY and WREADY SHALL pulse high together for exactly that one cycle.
REQ-012 Register update SHALL occur on the acceptance edge; only bytes with WSTRB=1 are written.
REQ-013 BVALID SHALL rise the cycle after acceptance and hold until BREADY is sampled high.
REQ-014 BRESP SHALL be OKAY (00) for RW and STATUS writes; SLVERR (10) for CH or unmapped writes, which have no effect.
REQ-015 A read SHALL be accepted when ARVALID is high and RVALID is low; ARREADY SHALL pulse for one cycle.
REQ-016 RVALID SHALL rise the cycle after acceptance, with RDATA/RRESP held stable until RREADY is sampled high.
REQ-017 RRESP SHALL be OKAY for mapped addresses; SLVERR for unmapped, with RDATA=0.
REQ-018 On sample_valid, all channels SHALL be captured into live registers simultaneously.
REQ-019 A read of CH0 SHALL copy all live channels into hold registers in the same cycle; CH0 returns the live value, and CH1..n-1 reads return hold values, giving a coherent vector.
REQ-020 CH reads SHALL return the sample sign-extended to 32 bits.
REQ-021 STATUS bit0 NEW SHALL be set by sample_valid and cleared by a CH0 read or by writing 1 to bit0.
REQ-022 STATUS bit1 OVR SHALL be set by sample_valid while NEW=1, and cleared only by writing 1 to bit1; other STATUS bits read 0.
REQ-023 Set SHALL win over clear: sample_valid in the same cycle as a CH0 read or W1C leaves NEW=1.
REQ-024 irq SHALL be registered: irq = NEW & IE, one cycle after either changes.
REQ-025 Read and write channels SHALL be independent and may complete in the same cycle; a same-cycle write to a register being read returns the pre-write value.

Reset
REQ-026 While S_AXI_ARESETN=0: all READY/VALID outputs=0, BRESP=RRESP=00, RDATA=0, all RW/live/hold registers=0, NEW=OVR=0, irq=0.
REQ-027 Reset asserted mid-transaction SHALL abort it; no partial write may persist, and no response is issued after release.

Structure
REQ-028 Package accel_axi_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants, STATUS bit indices, and the IE bit index.
REQ-029 One sub-module, accel_sample_capture (live/hold registers, NEW/OVR, irq), SHALL be instantiated; AXI handshake and decode stay in the top level.

Verification
REQ-030 Write 0xABCD0001 to index 1 with WSTRB=1111, then read it back -> BRESP=00, RDATA=0xABCD0001, RRESP=00.
REQ-031 Write 0xFFFFFFFF with WSTRB=0101 over 0x0 -> reads 0x00FF00FF.
REQ-032 IE=1, sample_data CH0=0x8000, CH1=0x0005 -> irq high 1 cycle after NEW sets; CH0 read=0xFFFF8000, NEW cleared; a new sample arriving before the CH1 read still makes CH1 read 0x00000005.
REQ-033 Two sample_valid pulses with no read -> STATUS=0x3; W1C 0x2 -> STATUS=0x1; sample_valid on the same cycle as W1C 0x1 -> NEW remains 1.
REQ-034 Write to CH1 and read of unmapped index 0xF -> SLVERR on both, RDATA=0, no register changes.
REQ-035 BREADY held low for 5 cycles, with AWVALID/WVALID held high -> BVALID stays high, no second AWREADY until BREADY is seen; reset pulse mid-wait -> all outputs 0 immediately.
